// File: rtl/serial_adder_pkg.sv
// Package shared by the serial adder files.
// Contents:
//   DEFAULT_WIDTH - default operand/result width of serial_adder
//   state_t       - control FSM states (IDLE, RUN, DONE)
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit adder cells used by the serial adder datapath.
//
// student_half_adder
//   a, b  : input  1 - addend bits
//   sum   : output 1 - a xor b
//   cout  : output 1 - a and b
//
// student_full_adder (two half adders plus an OR for the carry)
//   a, b  : input  1 - addend bits
//   cin   : input  1 - carry in
//   sum   : output 1 - a xor b xor cin
//   cout  : output 1 - carry out
module student_half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b;
    assign cout = a & b;

endmodule

module student_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic w_ha0_sum;
    logic w_ha0_cout;
    logic w_ha1_cout;

    student_half_adder u_ha0 (
        .a    (a),
        .b    (b),
        .sum  (w_ha0_sum),
        .cout (w_ha0_cout)
    );

    student_half_adder u_ha1 (
        .a    (w_ha0_sum),
        .b    (cin),
        .sum  (sum),
        .cout (w_ha1_cout)
    );

    // Both half adders can never carry at once, so OR is the full carry.
    assign cout = w_ha0_cout | w_ha1_cout;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: computes a+b LSB first, one bit per clock, through a
// single one-bit full adder.
//
// Parameter:
//   WIDTH : operand/result width, 1..32
// Ports:
//   clk   : input  1     - clock, rising edge
//   rst_n : input  1     - asynchronous active-low reset
//   start : input  1     - request an addition (accepted in IDLE or DONE)
//   a, b  : input  WIDTH - operands, sampled only on the accepting edge
//   busy  : output 1     - addition in progress (RUN)
//   done  : output 1     - one-cycle pulse, sum/carry hold a new result
//   sum   : output WIDTH - registered a+b mod 2^WIDTH
//   carry : output 1     - registered carry out of the MSB
//
// All outputs come straight from registers, so no input reaches an output
// combinationally. sum/carry change only on the RUN->DONE transition.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum_sh;
    logic             r_c;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;

    logic             w_accept;
    logic             w_last;
    logic             w_fa_sum;
    logic             w_fa_cout;
    logic [WIDTH-1:0] w_sum_sh_next;

    // A new request is taken in IDLE and also in DONE (back-to-back).
    assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last   = (r_state == RUN) && (r_cnt == LAST_BIT);

    student_full_adder u_fa (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .cin  (r_c),
        .sum  (w_fa_sum),
        .cout (w_fa_cout)
    );

    // Sum bits enter at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    generate
        if (WIDTH == 1) begin : g_w1
            assign w_sum_sh_next = w_fa_sum;
            logic w_unused_sh;
            assign w_unused_sh = r_sum_sh[0];
        end else begin : g_wn
            assign w_sum_sh_next = {w_fa_sum, r_sum_sh[WIDTH-1:1]};
            // The oldest bit falls off on the final shift; the finished
            // word is taken from w_sum_sh_next instead.
            logic w_unused_sh;
            assign w_unused_sh = r_sum_sh[0];
        end
    endgenerate

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (start) w_state_next = RUN;
            RUN:  if (w_last) w_state_next = DONE;
            DONE: w_state_next = start ? RUN : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath: operand/sum shift registers, internal carry, bit counter,
    // and the output result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_sum_sh <= '0;
            r_c      <= 1'b0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_carry  <= 1'b0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_c   <= 1'b0;
            r_cnt <= '0;
        end else if (r_state == RUN) begin
            r_a      <= r_a >> 1;
            r_b      <= r_b >> 1;
            r_sum_sh <= w_sum_sh_next;
            r_c      <= w_fa_cout;
            r_cnt    <= r_cnt + CW'(1);
            if (w_last) begin
                r_sum   <= w_sum_sh_next;
                r_carry <= w_fa_cout;
            end
        end
    end

    assign busy  = (r_state == RUN);
    assign done  = (r_state == DONE);
    assign sum   = r_sum;
    assign carry = r_carry;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    logic       clk;
    logic       rst_n;

    // WIDTH=8 instance
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       carry;

    // WIDTH=1 instance
    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       carry1;

    int n_checks;
    int n_fail;
    logic [8:0] last8;   // result the 8-bit outputs must currently hold

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .carry (carry)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .carry (carry1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Watch n cycles with no request; neither done nor busy may appear.
    task automatic quiet(input int n, input string tag);
        int d;
        int bz;
        d  = 0;
        bz = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (done) d++;
            if (busy) bz++;
        end
        check_val({tag, "_done"}, 32'(d), 32'd0);
        check_val({tag, "_busy"}, 32'(bz), 32'd0);
    endtask

    // One 8-bit addition. Called just after a rising edge while the DUT is
    // in IDLE or DONE. glitch>0 pulses start with other operands during RUN;
    // hold keeps start high so the next call chains back-to-back.
    task automatic op8(input logic [7:0] av, input logic [7:0] bv,
                       input int glitch, input bit hold);
        logic [8:0] exp;
        int  busy_n;
        int  both;
        int  hold_err;
        int  lat;
        bit  seen;
        exp      = 9'(av) + 9'(bv);
        busy_n   = 0;
        both     = 0;
        hold_err = 0;
        lat      = 0;
        seen     = 1'b0;
        start = 1'b1;
        a     = av;
        b     = bv;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        for (int m = 0; m < 20 && !seen; m++) begin
            if (busy && done) both++;
            if (done) begin
                seen = 1'b1;
                lat  = m + 1;     // the accepting cycle counts as cycle 1
            end else begin
                if (busy) busy_n++;
                if ({carry, sum} !== last8) hold_err++;
                if (glitch > 0 && m == glitch) begin
                    start = 1'b1;
                    a     = 8'h01;
                    b     = 8'h01;
                end
                @(posedge clk); #1;
                if (!hold) start = 1'b0;
                a = 8'($urandom);
                b = 8'($urandom);
            end
        end
        check_val("done_seen", 32'(seen), 32'd1);
        check_val("latency", 32'(lat), 32'd9);
        check_val("busy_cycles", 32'(busy_n), 32'd8);
        check_val("busy_and_done", 32'(both), 32'd0);
        check_val("result_hold", 32'(hold_err), 32'd0);
        check_val("sum", 32'(sum), 32'(exp[7:0]));
        check_val("carry", 32'(carry), 32'(exp[8]));
        $display("op8 a=%02h b=%02h glitch=%0d hold=%0d -> sum=%02h carry=%0d latency=%0d",
                 av, bv, glitch, hold, sum, carry, lat);
        last8 = exp;
    endtask

    // One 1-bit addition on the WIDTH=1 instance.
    task automatic op1(input logic av, input logic bv);
        logic [1:0] exp;
        int  lat;
        int  busy_n;
        bit  seen;
        exp    = 2'(av) + 2'(bv);
        lat    = 0;
        busy_n = 0;
        seen   = 1'b0;
        start1 = 1'b1;
        a1     = av;
        b1     = bv;
        @(posedge clk); #1;
        start1 = 1'b0;
        a1     = ~av;
        b1     = ~bv;
        for (int m = 0; m < 10 && !seen; m++) begin
            if (done1) begin
                seen = 1'b1;
                lat  = m + 1;
            end else begin
                if (busy1) busy_n++;
                @(posedge clk); #1;
            end
        end
        check_val("w1_done_seen", 32'(seen), 32'd1);
        check_val("w1_latency", 32'(lat), 32'd2);
        check_val("w1_busy_cycles", 32'(busy_n), 32'd1);
        check_val("w1_result", 32'({carry1, sum1}), 32'(exp));
        $display("op1 a=%0d b=%0d -> carry=%0d sum=%0d latency=%0d",
                 av, bv, carry1, sum1, lat);
        @(posedge clk); #1;
    endtask

    initial begin
        int g;
        bit h;
        n_checks = 0;
        n_fail   = 0;
        last8    = '0;
        start  = 1'b0; a  = '0; b  = '0;
        start1 = 1'b0; a1 = '0; b1 = '0;
        rst_n  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_sum", 32'(sum), 32'd0);
        check_val("rst_carry", 32'(carry), 32'd0);
        check_val("rst_w1_out", 32'({busy1, done1, carry1, sum1}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed operand patterns.
        op8(8'h00, 8'h00, 0, 1'b0);
        op8(8'hFF, 8'h01, 0, 1'b0);
        op8(8'hA5, 8'h5A, 0, 1'b0);
        quiet(3, "idle");

        // Start pulsed during RUN is ignored; no second done.
        op8(8'h10, 8'h20, 3, 1'b0);
        quiet(12, "after_glitch");

        // Start held through DONE chains directly into the next operation.
        op8(8'h33, 8'h44, 0, 1'b1);
        op8(8'hC8, 8'h64, 0, 1'b0);
        quiet(3, "after_chain");

        // Reset three cycles into RUN.
        op8(8'h7F, 8'h01, 0, 1'b0);
        start = 1'b1;
        a     = 8'h55;
        b     = 8'h66;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("pre_rst_busy", 32'(busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_val("async_rst_busy", 32'(busy), 32'd0);
        check_val("async_rst_done", 32'(done), 32'd0);
        check_val("async_rst_sum", 32'(sum), 32'd0);
        check_val("async_rst_carry", 32'(carry), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        last8 = '0;
        quiet(12, "after_rst");
        op8(8'h12, 8'h34, 0, 1'b0);

        // Randomized operations, glitches and back-to-back chaining.
        for (int i = 0; i < 16; i++) begin
            g = $urandom_range(0, 7);
            h = (i == 15) ? 1'b0 : 1'($urandom_range(0, 1));
            op8(8'($urandom), 8'($urandom), g, h);
            if (!h && $urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        quiet(2, "end8");

        // WIDTH=1: all four operand combinations.
        for (int i = 0; i < 4; i++) begin
            op1(1'(i >> 1), 1'(i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
